// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - two-requester round-robin HEX display scanner
// One shared hex-to-7-segment decoder is walked over six persistent display registers.
module hex_display_ctrl #(
    parameter int         NUM_DIGITS = 6,
    parameter logic [6:0] BLANK_SEG  = 7'h7F
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [1:0]  req_valid,
    input  logic [23:0] req_value0,
    input  logic [23:0] req_value1,
    input  logic [5:0]  req_mask0,
    input  logic [5:0]  req_mask1,
    output logic [1:0]  req_ready,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic        busy,
    output logic        done,
    output logic        owner
);

    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t      state;
    logic [2:0]  digit;
    logic [23:0] cap_value;
    logic [5:0]  cap_mask;
    logic        last_owner;
    logic [6:0]  hex_q [NUM_DIGITS];

    logic [1:0]  grant;
    logic        accept;
    logic [3:0]  nibble;
    logic        digit_en;
    logic [6:0]  seg;
    logic [6:0]  seg_out;

    // Ties go to whichever requester did not win the previous frame.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_owner ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    always_comb begin
        nibble   = cap_value[3:0];
        digit_en = cap_mask[0];
        case (digit)
            3'd0: begin nibble = cap_value[3:0];   digit_en = cap_mask[0]; end
            3'd1: begin nibble = cap_value[7:4];   digit_en = cap_mask[1]; end
            3'd2: begin nibble = cap_value[11:8];  digit_en = cap_mask[2]; end
            3'd3: begin nibble = cap_value[15:12]; digit_en = cap_mask[3]; end
            3'd4: begin nibble = cap_value[19:16]; digit_en = cap_mask[4]; end
            3'd5: begin nibble = cap_value[23:20]; digit_en = cap_mask[5]; end
            default: begin nibble = cap_value[3:0]; digit_en = 1'b0; end
        endcase
    end

    // Active-low segments, bit 0 = segment a.
    always_comb begin
        seg = BLANK_SEG;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = BLANK_SEG;
        endcase
    end

    assign seg_out = digit_en ? seg : BLANK_SEG;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            digit      <= 3'd0;
            cap_value  <= 24'h0;
            cap_mask   <= 6'h0;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                hex_q[k] <= BLANK_SEG;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_value  <= grant[1] ? req_value1 : req_value0;
                        cap_mask   <= grant[1] ? req_mask1 : req_mask0;
                        owner      <= grant[1];
                        last_owner <= grant[1];
                        digit      <= 3'd0;
                        busy       <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (digit == 3'(k)) begin
                            hex_q[k] <= seg_out;
                        end
                    end
                    if (digit == LAST_DIGIT) begin
                        digit <= 3'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        digit <= digit + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - self-checking bench for hex_display_ctrl
// Frame-level reference model: displays are derived from cycles elapsed since each accept.
module tb_hex_display_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid;
    logic [23:0] req_value0, req_value1;
    logic [5:0]  req_mask0, req_mask1;
    logic [1:0]  req_ready;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic        busy, done, owner;

    hex_display_ctrl dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_value0 (req_value0),
        .req_value1 (req_value1),
        .req_mask0  (req_mask0),
        .req_mask1  (req_mask1),
        .req_ready  (req_ready),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5),
        .busy       (busy),
        .done       (done),
        .owner      (owner)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [6:0] hexs [6];
    assign hexs[0] = HEX0;
    assign hexs[1] = HEX1;
    assign hexs[2] = HEX2;
    assign hexs[3] = HEX3;
    assign hexs[4] = HEX4;
    assign hexs[5] = HEX5;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: one frame descriptor plus the display contents before that frame.
    int          n;
    int          start;
    bit          active;
    logic [23:0] capv;
    logic [5:0]  capm;
    logic [6:0]  old_disp [6];
    bit          m_last;
    bit          m_owner;
    logic [1:0]  acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
        end
    endtask

    task automatic model_reset();
        active  = 1'b0;
        start   = n;
        m_last  = 1'b1;
        m_owner = 1'b0;
        for (int k = 0; k < 6; k++) old_disp[k] = 7'h7F;
    endtask

    function automatic logic [6:0] disp_at(input int k, input int el);
        logic [3:0] nib;
        nib = capv[4*k +: 4];
        if (active && el >= k + 1) return capm[k] ? seg_tab[nib] : 7'h7F;
        return old_disp[k];
    endfunction

    function automatic logic [1:0] m_grant(input logic [1:0] v);
        if (v == 2'b01) return 2'b01;
        if (v == 2'b10) return 2'b10;
        if (v == 2'b11) return m_last ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    task automatic check_outputs();
        int el;
        el = n - start;
        for (int k = 0; k < 6; k++) chk($sformatf("HEX%0d", k), 32'(hexs[k]), 32'(disp_at(k, el)));
        chk("busy", 32'(busy), 32'(active && el < 6));
        chk("done", 32'(done), 32'(active && el == 6));
        chk("owner", 32'(owner), 32'(m_owner));
    endtask

    task automatic step();
        logic [1:0] g;
        int el;
        #1;
        el = n - start;
        g = (!active || el >= 6) ? m_grant(req_valid) : 2'b00;
        chk("req_ready", 32'(req_ready), 32'(g));
        @(posedge CLOCK_50);
        acc = 2'b00;
        n++;
        if (!resetn) begin
            model_reset();
        end else if (g != 2'b00) begin
            for (int k = 0; k < 6; k++) old_disp[k] = disp_at(k, n - 1 - start);
            capv    = g[1] ? req_value1 : req_value0;
            capm    = g[1] ? req_mask1 : req_mask0;
            m_owner = g[1];
            m_last  = g[1];
            start   = n;
            active  = 1'b1;
            acc     = g;
        end
        @(negedge CLOCK_50);
        check_outputs();
    endtask

    task automatic reset_pulse();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    initial begin
        logic [6:0] exp1 [6];
        n          = 0;
        resetn     = 1'b0;
        req_valid  = 2'b00;
        req_value0 = 24'h0;
        req_value1 = 24'h0;
        req_mask0  = 6'h0;
        req_mask1  = 6'h0;
        acc        = 2'b00;
        model_reset();
        @(negedge CLOCK_50);
        check_outputs();
        chk("reset_HEX0", 32'(HEX0), 32'h7F);
        chk("reset_owner", 32'(owner), 32'h0);
        step();
        resetn = 1'b1;

        // Single frame, all digits enabled: nibble k of 123456 lands on HEXk.
        exp1 = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        req_valid  = 2'b01;
        req_value0 = 24'h123456;
        req_mask0  = 6'h3F;
        step();
        chk("t1_busy", 32'(busy), 32'h1);
        req_valid = 2'b00;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("t1_HEX%0d", k), 32'(hexs[k]), 32'(exp1[k]));
        end
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_owner", 32'(owner), 32'h0);
        step();
        chk("t1_done_clear", 32'(done), 32'h0);

        // Tie after reset: 0 first, then 1 at E7 with a masked value.
        reset_pulse();
        req_valid  = 2'b11;
        req_value0 = 24'hABCDEF;
        req_value1 = 24'hFEDCBA;
        req_mask1  = 6'b000101;
        #1 chk("t2_ready_first", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b10;
        for (int k = 0; k < 6; k++) step();
        #1 chk("t2_ready_E7", 32'(req_ready), 32'h2);
        step();
        chk("t2_owner", 32'(owner), 32'h1);
        req_valid = 2'b00;
        for (int k = 0; k < 6; k++) step();
        chk("t2_HEX0", 32'(HEX0), 32'h08);
        chk("t2_HEX1", 32'(HEX1), 32'h7F);
        chk("t2_HEX2", 32'(HEX2), 32'h46);
        chk("t2_HEX3", 32'(HEX3), 32'h7F);
        chk("t2_HEX5", 32'(HEX5), 32'h7F);
        step();

        // Value changes while scanning must not leak into the displays.
        req_valid  = 2'b01;
        req_value0 = 24'h0F1E2D;
        req_mask0  = 6'h3F;
        step();
        for (int k = 0; k < 6; k++) begin
            req_value0 = 24'($urandom);
            step();
        end
        chk("t3_HEX0", 32'(HEX0), 32'h21);
        chk("t3_HEX5", 32'(HEX5), 32'h40);
        step();
        req_valid = 2'b00;
        for (int k = 0; k < 7; k++) step();

        // Reset in the middle of a scan.
        req_valid  = 2'b01;
        req_value0 = 24'h888888;
        step();
        for (int k = 0; k < 3; k++) step();
        resetn = 1'b0;
        #1;
        chk("t4_HEX0", 32'(HEX0), 32'h7F);
        chk("t4_HEX2", 32'(HEX2), 32'h7F);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_done", 32'(done), 32'h0);
        model_reset();
        step();
        step();
        resetn = 1'b1;
        step();
        chk("t4_reaccept_busy", 32'(busy), 32'h1);
        chk("t4_reaccept_owner", 32'(owner), 32'h0);
        req_valid = 2'b00;
        for (int k = 0; k < 8; k++) step();

        // Both valid continuously: grants alternate every 7 cycles.
        reset_pulse();
        req_valid = 2'b11;
        for (int f = 0; f < 4; f++) begin
            step();
            chk($sformatf("t5_owner_f%0d", f), 32'(owner), 32'(f % 2));
            for (int k = 0; k < 6; k++) step();
        end
        req_valid = 2'b00;
        for (int k = 0; k < 8; k++) step();

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (acc[i] || (!req_valid[i] && $urandom_range(2) == 0)) begin
                    req_valid[i] = acc[i] ? 1'($urandom_range(1)) : 1'b1;
                    if (i == 0) begin
                        req_value0 = 24'($urandom);
                        req_mask0  = 6'($urandom);
                    end else begin
                        req_value1 = 24'($urandom);
                        req_mask1  = 6'($urandom);
                    end
                end else if (req_valid[i] && $urandom_range(15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
